// File: rtl/pp_pipeline_accel_fifo_param.sv
// Parametrised stream FIFO for pp_pipeline_accel dataflow channels.
// Shift-register storage of DEPTH entries, optionally fronted by a single
// output register (OUT_REG=1) so if_dout is a clean flop output.
// Keeps the HLS if_* handshake; adds occupancy, threshold and error flags.
module pp_pipeline_accel_fifo_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 3,
  parameter int ADDR_WIDTH = $clog2(DEPTH+1),
  parameter int OUT_REG    = 0,
  parameter int AF_THRESH  = DEPTH+OUT_REG-1,
  parameter int AE_THRESH  = 1
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  if_overflow,
  output logic                  if_underflow
);

  localparam int CW  = ADDR_WIDTH+1;
  localparam int CAP = DEPTH+OUT_REG;
  localparam logic [CW-1:0] CAP_C = CW'(CAP);
  localparam logic [CW-1:0] AF_C  = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C  = CW'(AE_THRESH);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic                             wreq, rreq, wr, rd;
  logic                             full_n, empty_n;
  logic [CW-1:0]                    cnt;     // total occupancy incl. output reg
  logic [CW-1:0]                    s_cnt;   // shift-register occupancy
  logic                             s_nz, s_push, s_pop;
  logic [CW-1:0]                    raddr;
  logic [DATA_WIDTH-1:0]            rdata;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  assign wreq   = if_write & if_write_ce;
  assign rreq   = if_read & if_read_ce;
  assign full_n = (cnt < CAP_C);
  assign wr     = wreq & full_n;
  assign rd     = rreq & empty_n;
  assign s_nz   = (s_cnt != '0);
  // Oldest entry sits at occupancy-1; park on 0 when storage is empty.
  assign raddr  = s_nz ? (s_cnt - ONE) : '0;

  // Storage read mux, compared against a full-width address so any DEPTH works.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++)
      if (raddr == CW'(i)) rdata = mem[i];
  end

  // Shift storage; data is not reset, only the occupancy is.
  always_ff @(posedge clk) begin
    if (s_push) begin
      mem[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  // Total occupancy: +1 on accepted write, -1 on accepted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else begin
      case ({wr, rd})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage occupancy tracks pushes into and pops out of the shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) s_cnt <= '0;
    else begin
      case ({s_push, s_pop})
        2'b10:   s_cnt <= s_cnt + ONE;
        2'b01:   s_cnt <= s_cnt - ONE;
        default: s_cnt <= s_cnt;
      endcase
    end
  end

  // Sticky error flags: rejected requests are remembered until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_overflow  <= 1'b0;
      if_underflow <= 1'b0;
    end else begin
      if_overflow  <= if_overflow  | (wreq & ~full_n);
      if_underflow <= if_underflow | (rreq & ~empty_n);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  ovld;
      logic [DATA_WIDTH-1:0] odata;
      logic                  load;

      // Output slot refills whenever it is free or being consumed.
      // Storage empty + slot refilling means a write bypasses straight in.
      always_comb begin
        load   = ~ovld | rd;
        s_pop  = load & s_nz;
        s_push = wr & ~(load & ~s_nz);
      end

      // Output register: oldest storage entry first, else bypass, else drain.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovld  <= 1'b0;
          odata <= '0;
        end else if (load) begin
          if (s_nz) begin
            odata <= rdata;
            ovld  <= 1'b1;
          end else if (wr) begin
            odata <= if_din;
            ovld  <= 1'b1;
          end else begin
            ovld  <= 1'b0;
          end
        end
      end

      assign empty_n = ovld;
      assign if_dout = odata;
    end else begin : g_noreg
      assign s_push  = wr;
      assign s_pop   = rd;
      assign empty_n = (cnt != '0);
      assign if_dout = rdata;
    end
  endgenerate

  assign if_full_n         = full_n;
  assign if_empty_n        = empty_n;
  assign if_num_data_valid = cnt;
  assign if_fifo_cap       = CAP_C;
  assign if_almost_full    = (cnt >= AF_C);
  assign if_almost_empty   = (cnt <= AE_C);

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_param.sv
// Directed bench for pp_pipeline_accel_fifo_param. Three instances share
// clock, reset and request inputs; each phase checks only the instance
// whose configuration it targets.
module tb_pp_pipeline_accel_fifo_param;

  logic        clk, reset;
  logic        wr, wce, rd, rce;
  logic [15:0] din;

  // A: DEPTH=5, OUT_REG=0 (AF=4, AE=1)
  logic [15:0] a_dout;
  logic        a_full_n, a_empty_n, a_af, a_ae, a_ovf, a_unf;
  logic [3:0]  a_cnt, a_cap;
  // B: DEPTH=3, OUT_REG=1 (AF=3, AE=1)
  logic [15:0] b_dout;
  logic        b_full_n, b_empty_n, b_af, b_ae, b_ovf, b_unf;
  logic [2:0]  b_cnt, b_cap;
  // C: DEPTH=8, OUT_REG=0, AF=6, AE=2
  logic [15:0] c_dout;
  logic        c_full_n, c_empty_n, c_af, c_ae, c_ovf, c_unf;
  logic [4:0]  c_cnt, c_cap;

  int n_tests, n_fail;

  pp_pipeline_accel_fifo_param #(.DATA_WIDTH(16), .DEPTH(5)) u_a (
    .clk(clk), .reset(reset),
    .if_write(wr), .if_write_ce(wce), .if_din(din), .if_full_n(a_full_n),
    .if_read(rd), .if_read_ce(rce), .if_dout(a_dout), .if_empty_n(a_empty_n),
    .if_num_data_valid(a_cnt), .if_fifo_cap(a_cap),
    .if_almost_full(a_af), .if_almost_empty(a_ae),
    .if_overflow(a_ovf), .if_underflow(a_unf));

  pp_pipeline_accel_fifo_param #(.DATA_WIDTH(16), .DEPTH(3), .OUT_REG(1)) u_b (
    .clk(clk), .reset(reset),
    .if_write(wr), .if_write_ce(wce), .if_din(din), .if_full_n(b_full_n),
    .if_read(rd), .if_read_ce(rce), .if_dout(b_dout), .if_empty_n(b_empty_n),
    .if_num_data_valid(b_cnt), .if_fifo_cap(b_cap),
    .if_almost_full(b_af), .if_almost_empty(b_ae),
    .if_overflow(b_ovf), .if_underflow(b_unf));

  pp_pipeline_accel_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) u_c (
    .clk(clk), .reset(reset),
    .if_write(wr), .if_write_ce(wce), .if_din(din), .if_full_n(c_full_n),
    .if_read(rd), .if_read_ce(rce), .if_dout(c_dout), .if_empty_n(c_empty_n),
    .if_num_data_valid(c_cnt), .if_fifo_cap(c_cap),
    .if_almost_full(c_af), .if_almost_empty(c_ae),
    .if_overflow(c_ovf), .if_underflow(c_unf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr = 1'b0; rd = 1'b0; wce = 1'b1; rce = 1'b1;
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    wr = 1'b0; rd = 1'b0; wce = 1'b1; rce = 1'b1; din = '0;
    reset = 1'b1;
    #12 reset = 1'b0;

    // ---- reset behaviour on A ----
    rd = 1'b1; tick();                           // read while empty
    rd = 1'b0; wr = 1'b1; din = 16'h0001; tick();
    din = 16'h0002; tick();
    wr = 1'b0;
    chk("a_unf_set", 32'(a_unf), 1);
    chk("a_cnt2", 32'(a_cnt), 2);
    wr = 1'b1; wce = 1'b0; din = 16'h0009; tick(); // clock-enable low: ignored
    wr = 1'b0; wce = 1'b1;
    chk("a_ce_gate", 32'(a_cnt), 2);
    #2 reset = 1'b1;
    #1;
    chk("rst_empty_n", 32'(a_empty_n), 0);
    chk("rst_full_n", 32'(a_full_n), 1);
    chk("rst_cnt", 32'(a_cnt), 0);
    chk("rst_ae", 32'(a_ae), 1);
    chk("rst_af", 32'(a_af), 0);
    chk("rst_ovf", 32'(a_ovf), 0);
    chk("rst_unf", 32'(a_unf), 0);
    chk("rst_cap", 32'(a_cap), 5);
    chk("rst_b_empty_n", 32'(b_empty_n), 0);
    #2 reset = 1'b0;

    // ---- fill/drain on A (DEPTH=5) ----
    wr = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      din = 16'(i);
      tick();
      chk("a_fill_cnt", 32'(a_cnt), 32'(i));
    end
    wr = 1'b0;
    chk("a_full_n", 32'(a_full_n), 0);
    chk("a_af", 32'(a_af), 1);
    rd = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("a_drain_dout", 32'(a_dout), 32'(i));
      tick();
    end
    rd = 1'b0;
    chk("a_empty_n", 32'(a_empty_n), 0);

    // ---- simultaneous events on A ----
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 16'h0011 + 16'(i);
      tick();
    end
    din = 16'h00AA; rd = 1'b1; tick();           // full: only read accepted
    wr = 1'b0;
    chk("a_full_both_cnt", 32'(a_cnt), 4);
    chk("a_ovf", 32'(a_ovf), 1);
    for (int i = 0; i < 4; i++) begin
      chk("a_after_ovf_dout", 32'(a_dout), 32'h12 + 32'(i));
      tick();
    end
    rd = 1'b0;
    chk("a_empty_cnt", 32'(a_cnt), 0);
    chk("a_unf_clear", 32'(a_unf), 0);
    wr = 1'b1; rd = 1'b1; din = 16'h00AA; tick(); // empty: only write accepted
    wr = 1'b0; rd = 1'b0;
    chk("a_empty_both_cnt", 32'(a_cnt), 1);
    chk("a_empty_both_dout", 32'(a_dout), 32'h00AA);
    chk("a_unf", 32'(a_unf), 1);

    // ---- OUT_REG=1 bypass on B (DEPTH=3, cap 4) ----
    do_reset();
    wr = 1'b1; din = 16'h1234; tick();
    wr = 1'b0;
    chk("b_byp_empty_n", 32'(b_empty_n), 1);
    chk("b_byp_dout", 32'(b_dout), 32'h1234);
    chk("b_byp_cnt", 32'(b_cnt), 1);
    chk("b_cap", 32'(b_cap), 4);
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 16'h2000 + 16'(i);
      tick();
    end
    wr = 1'b0;
    chk("b_full_cnt", 32'(b_cnt), 4);
    chk("b_full_n", 32'(b_full_n), 0);
    chk("b_af", 32'(b_af), 1);
    rd = 1'b1;
    chk("b_drain0", 32'(b_dout), 32'h1234);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("b_drain", 32'(b_dout), 32'h2000 + 32'(i));
      tick();
    end
    rd = 1'b0;
    chk("b_empty_n", 32'(b_empty_n), 0);
    chk("b_empty_cnt", 32'(b_cnt), 0);
    wr = 1'b1; din = 16'h3000; tick();
    din = 16'h3001; tick();
    din = 16'h3002; rd = 1'b1; tick();           // steady-state read+write
    wr = 1'b0; rd = 1'b0;
    chk("b_rw_cnt", 32'(b_cnt), 2);
    chk("b_rw_dout", 32'(b_dout), 32'h3001);

    // ---- thresholds on C (DEPTH=8, AF=6, AE=2) ----
    do_reset();
    chk("c_rst_ae", 32'(c_ae), 1);
    wr = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      din = 16'h0100 + 16'(i);
      tick();
      chk("c_ae", 32'(c_ae), (i <= 2) ? 1 : 0);
      chk("c_af", 32'(c_af), (i >= 6) ? 1 : 0);
    end
    wr = 1'b0; rd = 1'b1; tick();
    rd = 1'b0;
    chk("c_af_fall", 32'(c_af), 0);
    chk("c_cnt5", 32'(c_cnt), 5);
    chk("c_dout", 32'(c_dout), 32'h0102);

    // ---- async reset mid-stream on B ----
    do_reset();
    wr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      din = 16'h00A0 + 16'(i);
      tick();
    end
    rd = 1'b1; din = 16'h00A4; tick();
    chk("b_mid_cnt", 32'(b_cnt), 3);
    chk("b_mid_dout", 32'(b_dout), 32'h00A2);
    #2 reset = 1'b1;
    #1;
    chk("b_async_cnt", 32'(b_cnt), 0);
    chk("b_async_empty_n", 32'(b_empty_n), 0);
    #2 reset = 1'b0;
    rd = 1'b0; wr = 1'b1; din = 16'h0F0F; tick();
    wr = 1'b0;
    chk("b_post_dout", 32'(b_dout), 32'h0F0F);
    chk("b_post_empty_n", 32'(b_empty_n), 1);
    chk("b_post_cnt", 32'(b_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
